// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU MEM stage
// and a debug/loader port. Grants at most one port per cycle (round-robin on
// ties), passes the granted access straight to the memory, and registers read
// data for return one cycle later. DBG may lock the memory across several
// cycles for multi-word sequences.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cpu_req/write/address/wdata   CPU access request (held until cpu_ready)
//   cpu_ready, cpu_stall          combinational grant / stall to the CPU
//   cpu_rvalid, cpu_read_data     registered read return (one-cycle pulse)
//   dbg_*                         same set for the DBG port (no stall output)
//   dbg_lock                      DBG keeps exclusive ownership while granted
//   mem_write/address/write_data  to data_memory
//   mem_read_data                 from data_memory (combinational read)
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic              cpu_ready,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_read_data,
  input  logic              dbg_req,
  input  logic              dbg_write,
  input  logic [ADDR_W-1:0] dbg_address,
  input  logic [DATA_W-1:0] dbg_write_data,
  input  logic              dbg_lock,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_read_data,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;   // 0 = CPU, 1 = DBG
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              grant_cpu, grant_dbg;

  // State and read-return registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Grant decision, next state, memory mux and read capture
  always_comb begin
    grant_cpu      = 1'b0;
    grant_dbg      = 1'b0;
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    cpu_rvalid_d   = 1'b0;
    dbg_rvalid_d   = 1'b0;
    cpu_rdata_d    = cpu_rdata_q;
    dbg_rdata_d    = dbg_rdata_q;
    mem_address    = cpu_address;
    mem_write_data = cpu_write_data;
    mem_write      = 1'b0;

    if (!reset) begin
      unique case (state_q)
        ARB: begin
          if (cpu_req && dbg_req) begin
            // tie: the port that did not win last time goes now
            grant_cpu = last_grant_q;
            grant_dbg = ~last_grant_q;
          end else begin
            grant_cpu = cpu_req;
            grant_dbg = dbg_req;
          end
          if (grant_dbg && dbg_lock) state_d = LOCK;
        end
        LOCK: begin
          // DBG may still be served in the cycle it releases the lock
          grant_dbg = dbg_req;
          if (!dbg_lock) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end

    if (grant_dbg) begin
      mem_address    = dbg_address;
      mem_write_data = dbg_write_data;
      mem_write      = dbg_write;
      last_grant_d   = 1'b1;
      if (!dbg_write) begin
        dbg_rvalid_d = 1'b1;
        dbg_rdata_d  = mem_read_data;
      end
    end else if (grant_cpu) begin
      mem_write    = cpu_write;
      last_grant_d = 1'b0;
      if (!cpu_write) begin
        cpu_rvalid_d = 1'b1;
        cpu_rdata_d  = mem_read_data;
      end
    end
  end

  assign cpu_ready     = grant_cpu;
  assign dbg_ready     = grant_dbg;
  assign cpu_stall     = cpu_req & ~grant_cpu;
  assign cpu_rvalid    = cpu_rvalid_q;
  assign dbg_rvalid    = dbg_rvalid_q;
  assign cpu_read_data = cpu_rdata_q;
  assign dbg_read_data = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a word-addressed memory model stands in for
// data_memory; expected read data comes from a separate shadow array and is
// queued per port when a read grant is expected, then popped on rvalid.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_write, cpu_ready, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_write_data, cpu_read_data;
  logic          dbg_req, dbg_write, dbg_lock, dbg_ready, dbg_rvalid;
  logic [AW-1:0] dbg_address;
  logic [DW-1:0] dbg_write_data, dbg_read_data;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data, mem_read_data;

  logic [DW-1:0] mem     [0:63];
  logic [DW-1:0] ref_mem [0:63];
  logic [DW-1:0] cpu_q[$];
  logic [DW-1:0] dbg_q[$];
  logic          cpu_pend, dbg_pend;
  int            nvec, nerr;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_write_data(cpu_write_data), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_read_data(cpu_read_data),
    .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_address(dbg_address),
    .dbg_write_data(dbg_write_data), .dbg_lock(dbg_lock), .dbg_ready(dbg_ready),
    .dbg_rvalid(dbg_rvalid), .dbg_read_data(dbg_read_data),
    .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // data_memory stand-in: combinational read, write on the rising edge
  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_address[7:2]] <= mem_write_data;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance past the rising edge
  task automatic cycle(input logic rst,
                       input logic creq, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                       input logic dreq, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                       input logic dlk,
                       input logic exp_cr, input logic exp_dr);
    logic exp_mw;
    logic [DW-1:0] pop;
    reset = rst;
    cpu_req = creq; cpu_write = cw; cpu_address = ca; cpu_write_data = cwd;
    dbg_req = dreq; dbg_write = dw; dbg_address = da; dbg_write_data = dwd;
    dbg_lock = dlk;
    @(negedge clk);
    exp_mw = (exp_cr & cw) | (exp_dr & dw);
    chk("cpu_ready", DW'(cpu_ready), DW'(exp_cr));
    chk("dbg_ready", DW'(dbg_ready), DW'(exp_dr));
    chk("cpu_stall", DW'(cpu_stall), DW'(creq & ~exp_cr));
    chk("mem_write", DW'(mem_write), DW'(exp_mw));
    if (exp_dr) begin
      chk("mem_address_dbg", mem_address, da);
      if (dw) chk("mem_wdata_dbg", mem_write_data, dwd);
    end else if (exp_cr) begin
      chk("mem_address_cpu", mem_address, ca);
      if (cw) chk("mem_wdata_cpu", mem_write_data, cwd);
    end
    chk("cpu_rvalid", DW'(cpu_rvalid), DW'(cpu_pend));
    if (cpu_pend && cpu_q.size() > 0) begin
      pop = cpu_q.pop_front();
      chk("cpu_read_data", cpu_read_data, pop);
    end
    chk("dbg_rvalid", DW'(dbg_rvalid), DW'(dbg_pend));
    if (dbg_pend && dbg_q.size() > 0) begin
      pop = dbg_q.pop_front();
      chk("dbg_read_data", dbg_read_data, pop);
    end
    cpu_pend = exp_cr & ~cw;
    dbg_pend = exp_dr & ~dw;
    if (cpu_pend) cpu_q.push_back(ref_mem[ca[7:2]]);
    if (dbg_pend) dbg_q.push_back(ref_mem[da[7:2]]);
    if (exp_cr && cw) ref_mem[ca[7:2]] = cwd;
    if (exp_dr && dw) ref_mem[da[7:2]] = dwd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rst);
    cycle(rst, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    nvec = 0; nerr = 0;
    cpu_pend = 1'b0; dbg_pend = 1'b0;
    for (int k = 0; k < 64; k++) begin
      mem[k]     = DW'(k);
      ref_mem[k] = DW'(k);
    end
    reset = 1'b1;
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_write_data = '0;
    dbg_req = 1'b0; dbg_write = 1'b0; dbg_address = '0; dbg_write_data = '0;
    dbg_lock = 1'b0;
    @(posedge clk);
    #1;

    // reset held with both ports requesting (DBG a write): nothing granted
    cycle(1'b1, 1'b1, 1'b0, 32'd12, '0, 1'b1, 1'b1, 32'd12, 32'hdead, 1'b0, 1'b0, 1'b0);
    chk("cpu_read_data_rst", cpu_read_data, '0);
    chk("dbg_read_data_rst", dbg_read_data, '0);

    // tie right after reset: CPU reads 20 first, DBG reads 12 next cycle
    cycle(1'b0, 1'b1, 1'b0, 32'd20, '0, 1'b1, 1'b0, 32'd12, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd12, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);

    // CPU-only read of address 12
    cycle(1'b0, 1'b1, 1'b0, 32'd12, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);

    // DBG writes 0 to 20, then CPU reads it back
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'd20, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'd20, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("cpu_read_data_hold", cpu_read_data, 32'd0);
    chk("dbg_read_data_hold", dbg_read_data, 32'd3);

    // locked DBG burst writes 7,8,9 to 0,4,8 while CPU keeps asking for 4
    cycle(1'b0, 1'b1, 1'b0, 32'd4, '0, 1'b1, 1'b1, 32'd0, 32'd7, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'd4, '0, 1'b1, 1'b1, 32'd4, 32'd8, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'd4, '0, 1'b1, 1'b1, 32'd8, 32'd9, 1'b1, 1'b0, 1'b1);
    // lock released: DBG still served this cycle (reads 8), CPU still waits
    cycle(1'b0, 1'b1, 1'b0, 32'd4, '0, 1'b1, 1'b0, 32'd8, '0, 1'b0, 1'b0, 1'b1);
    // back in ARB: tie goes to CPU (reads 4 -> 8), DBG (reads 0 -> 7) next
    cycle(1'b0, 1'b1, 1'b0, 32'd4, '0, 1'b1, 1'b0, 32'd0, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);

    // reset during a CPU read of 12: no rvalid, registers cleared
    cycle(1'b1, 1'b1, 1'b0, 32'd12, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("cpu_rvalid_after_rst", DW'(cpu_rvalid), '0);
    chk("cpu_read_data_clr", cpu_read_data, '0);
    chk("dbg_read_data_clr", dbg_read_data, '0);
    cycle(1'b0, 1'b1, 1'b0, 32'd12, '0, 1'b1, 1'b0, 32'd16, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd16, '0, 1'b0, 1'b0, 1'b1);

    // four idle cycles, then a tie: DBG won last, so CPU wins now
    idle(1'b0); idle(1'b0); idle(1'b0); idle(1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'd24, '0, 1'b1, 1'b0, 32'd28, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd28, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
